// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand-entry controller and the execution stage.
package alu_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_OPW   = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_DEC = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DONE    = 2'd2
  } exec_state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// Unsigned iterative shift-add multiplier: one partial product per cycle, WIDTH cycles.
module shift_add_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               finished
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               last_iter;

  assign last_iter = busy_q && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (last_iter) busy_d = 1'b0;
    end else if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      acc_d    = '0;
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  // The final sum is exposed during the last iteration so the caller can register it on that same edge.
  assign product  = acc_d;
  assign finished = last_iter;
  assign busy     = busy_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Execution stage: single-cycle ALU ops and an iterative multiply, with registered result, flags and done pulse.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OPW   = DEF_OPW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enAlu,
  input  logic               enMul,
  input  logic [OPW-1:0]     opcode,
  input  logic [WIDTH-1:0]   opA,
  input  logic [WIDTH-1:0]   opB,
  output logic [2*WIDTH-1:0] result,
  output logic               flag_z,
  output logic               flag_c,
  output logic               flag_n,
  output logic               flag_v,
  output logic               err,
  output logic               busy,
  output logic               done
);

  localparam int MSB = WIDTH - 1;

  exec_state_t        state_q, state_d;
  logic               en_alu_q, en_mul_q;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;
  logic               err_q, err_d, done_q, done_d;

  logic               start_alu, start_mul, mul_start;
  logic [2*WIDTH-1:0] mul_product;
  logic               mul_busy, mul_finished;

  logic [WIDTH:0]     arith;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, alu_err;

  assign start_alu = enAlu & ~en_alu_q;
  assign start_mul = enMul & ~en_mul_q;
  assign mul_start = (state_q == ST_IDLE) && start_mul;

  shift_add_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clock    (clock),
    .reset    (reset),
    .start    (mul_start),
    .a        (opA),
    .b        (opB),
    .product  (mul_product),
    .busy     (mul_busy),
    .finished (mul_finished)
  );

  always_comb begin
    arith   = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (opcode)
      OP_ADD: begin
        arith   = {1'b0, opA} + {1'b0, opB};
        alu_res = arith[WIDTH-1:0];
        alu_c   = arith[WIDTH];
        alu_v   = (opA[MSB] == opB[MSB]) && (alu_res[MSB] != opA[MSB]);
      end
      OP_SUB: begin
        arith   = {1'b0, opA} - {1'b0, opB};
        alu_res = arith[WIDTH-1:0];
        alu_c   = arith[WIDTH];
        alu_v   = (opA[MSB] != opB[MSB]) && (alu_res[MSB] != opA[MSB]);
      end
      OP_AND: alu_res = opA & opB;
      OP_OR:  alu_res = opA | opB;
      OP_XOR: alu_res = opA ^ opB;
      OP_NOT: alu_res = ~opA;
      OP_SHL: begin
        alu_res = {opA[WIDTH-2:0], 1'b0};
        alu_c   = opA[MSB];
      end
      OP_SHR: begin
        alu_res = {1'b0, opA[WIDTH-1:1]};
        alu_c   = opA[0];
      end
      OP_INC: begin
        arith   = {1'b0, opA} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = arith[WIDTH-1:0];
        alu_c   = arith[WIDTH];
        alu_v   = ~opA[MSB] & alu_res[MSB];
      end
      OP_DEC: begin
        arith   = {1'b0, opA} - {{WIDTH{1'b0}}, 1'b1};
        alu_res = arith[WIDTH-1:0];
        alu_c   = arith[WIDTH];
        alu_v   = opA[MSB] & ~alu_res[MSB];
      end
      default: alu_err = 1'b1;
    endcase
  end

  // Starts arriving outside IDLE are dropped; the edge registers below keep tracking regardless.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    z_d      = z_q;
    c_d      = c_q;
    n_d      = n_q;
    v_d      = v_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_mul) begin
          state_d = ST_MUL_RUN;
        end else if (start_alu) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = {{WIDTH{1'b0}}, alu_res};
          err_d    = alu_err;
          z_d      = ~alu_err && (alu_res == '0);
          c_d      = alu_c;
          n_d      = alu_res[MSB];
          v_d      = alu_v;
        end
      end
      ST_MUL_RUN: begin
        if (mul_finished) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = mul_product;
          err_d    = 1'b0;
          z_d      = (mul_product == '0);
          c_d      = 1'b0;
          n_d      = mul_product[2*WIDTH-1];
          v_d      = |mul_product[2*WIDTH-1:WIDTH];
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      en_alu_q <= 1'b0;
      en_mul_q <= 1'b0;
      result_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_alu_q <= enAlu;
      en_mul_q <= enMul;
      result_q <= result_d;
      z_q      <= z_d;
      c_q      <= c_d;
      n_q      <= n_d;
      v_q      <= v_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_n = n_q;
  assign flag_v = v_q;
  assign err    = err_q;
  assign busy   = mul_busy;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, randomized ALU/multiply ops, corner sequences.
module tb_alu_exec_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        enAlu, enMul;
  logic [3:0]  opcode;
  logic [7:0]  opA, opB;
  logic [15:0] result;
  logic        flag_z, flag_c, flag_n, flag_v, err, busy, done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        z, c, n, v, e;
  } vec_t;

  vec_t vecs[18];

  always #10 clock = ~clock;

  alu_exec_unit dut (
    .clock  (clock),
    .reset  (reset),
    .enAlu  (enAlu),
    .enMul  (enMul),
    .opcode (opcode),
    .opA    (opA),
    .opB    (opB),
    .result (result),
    .flag_z (flag_z),
    .flag_c (flag_c),
    .flag_n (flag_n),
    .flag_v (flag_v),
    .err    (err),
    .busy   (busy),
    .done   (done)
  );

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic on unsigned and signed views of the operands.
  function automatic vec_t aluModel(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    vec_t r;
    int ua, ub, sa, sb, full, sres;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    full = 0; sres = 0;
    r.op = op; r.a = a; r.b = b;
    r.c = 1'b0; r.v = 1'b0; r.e = 1'b0;
    case (op)
      4'd0: begin full = ua + ub; r.c = full > 255; sres = sa + sb; r.v = sres > 127 || sres < -128; end
      4'd1: begin full = ua - ub; r.c = ua < ub;    sres = sa - sb; r.v = sres > 127 || sres < -128; end
      4'd2: full = ua & ub;
      4'd3: full = ua | ub;
      4'd4: full = ua ^ ub;
      4'd5: full = 255 - ua;
      4'd6: begin full = ua * 2; r.c = ua >= 128; end
      4'd7: begin full = ua / 2; r.c = (ua % 2) == 1; end
      4'd8: begin full = ua + 1; r.c = full > 255; sres = sa + 1; r.v = sres > 127; end
      4'd9: begin full = ua - 1; r.c = ua < 1;     sres = sa - 1; r.v = sres < -128; end
      default: r.e = 1'b1;
    endcase
    r.res = r.e ? 16'h0 : 16'(full & 255);
    r.n = r.res[7];
    r.z = !r.e && (r.res == 16'h0);
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clock);
    opcode = v.op; opA = v.a; opB = v.b; enAlu = 1'b1;
    @(negedge clock);
    checkOutput({tag, ".done"}, 16'(done),   16'h1);
    checkOutput({tag, ".res"},  result,      v.res);
    checkOutput({tag, ".z"},    16'(flag_z), 16'(v.z));
    checkOutput({tag, ".c"},    16'(flag_c), 16'(v.c));
    checkOutput({tag, ".n"},    16'(flag_n), 16'(v.n));
    checkOutput({tag, ".v"},    16'(flag_v), 16'(v.v));
    checkOutput({tag, ".err"},  16'(err),    16'(v.e));
    checkOutput({tag, ".busy"}, 16'(busy),   16'h0);
    enAlu = 1'b0;
    @(negedge clock);
    checkOutput({tag, ".donePulse"}, 16'(done), 16'h0);
  endtask

  task automatic runMul(input logic [7:0] a, input logic [7:0] b, input logic withAlu, input string tag);
    int lat, busyCycles, prod;
    prod = int'(a) * int'(b);
    @(negedge clock);
    opcode = 4'd0; opA = a; opB = b; enMul = 1'b1;
    if (withAlu) enAlu = 1'b1;
    lat = 0; busyCycles = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (busy) busyCycles++;
      if (done) begin lat = k; break; end
    end
    checkOutput({tag, ".latency"}, 16'(lat), 16'd9);
    checkOutput({tag, ".busyCycles"}, 16'(busyCycles), 16'd8);
    checkOutput({tag, ".res"}, result, 16'(prod));
    checkOutput({tag, ".z"},   16'(flag_z), 16'(prod == 0));
    checkOutput({tag, ".c"},   16'(flag_c), 16'h0);
    checkOutput({tag, ".n"},   16'(flag_n), 16'(prod >= 32768));
    checkOutput({tag, ".v"},   16'(flag_v), 16'(prod > 255));
    checkOutput({tag, ".err"}, 16'(err),    16'h0);
    enMul = 1'b0;
    @(negedge clock);
    checkOutput({tag, ".donePulse"}, 16'(done), 16'h0);
  endtask

  initial begin
    int doneCount;
    vec_t rv;

    vecs[0]  = '{4'd0, 8'h33, 8'hFF, 16'h0032, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'd1, 8'h33, 8'hFF, 16'h0034, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{4'd0, 8'h7F, 8'h01, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{4'd0, 8'h80, 8'h80, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{4'd1, 8'h80, 8'h01, 16'h007F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{4'd6, 8'h81, 8'h00, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'd7, 8'h81, 8'h00, 16'h0040, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'd8, 8'hFF, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'd9, 8'h00, 8'h00, 16'h00FF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{4'd5, 8'h0F, 8'h00, 16'h00F0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{4'd4, 8'hAA, 8'hAA, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'd3, 8'h0F, 8'hF0, 16'h00FF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{4'hF, 8'h12, 8'h34, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{4'd2, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{4'd8, 8'h7F, 8'h00, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{4'd9, 8'h80, 8'h00, 16'h007F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{4'hA, 8'h01, 8'h01, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{4'd0, 8'h01, 8'h01, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b0; enAlu = 1'b0; enMul = 1'b0;
    opcode = 4'd0; opA = 8'h0; opB = 8'h0;
    repeat (3) @(negedge clock);
    checkOutput("reset.res",  result, 16'h0);
    checkOutput("reset.flags", 16'({flag_z, flag_c, flag_n, flag_v}), 16'h0);
    checkOutput("reset.err",  16'(err),  16'h0);
    checkOutput("reset.busy", 16'(busy), 16'h0);
    checkOutput("reset.done", 16'(done), 16'h0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 18; i++)
      applyStimulus(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      rv = aluModel(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      applyStimulus(rv, $sformatf("rnd%0d_op%0d", i, rv.op));
    end

    runMul(8'h33, 8'hFF, 1'b0, "mul33xFF");
    runMul(8'h00, 8'hA5, 1'b0, "mulZero");
    for (int i = 0; i < 6; i++)
      runMul(8'($urandom), 8'($urandom), 1'b0, $sformatf("mulRnd%0d", i));

    // Simultaneous starts: multiply wins, then the held ALU enable must not retrigger.
    runMul(8'h02, 8'h03, 1'b1, "simul");
    doneCount = 0;
    repeat (20) begin
      @(negedge clock);
      if (done) doneCount++;
    end
    checkOutput("holdEnAlu.extraDone", 16'(doneCount), 16'h0);
    enAlu = 1'b0;
    @(negedge clock);

    // Reset pulled low part-way through a multiply.
    opA = 8'hFF; opB = 8'hFF; enMul = 1'b1;
    repeat (5) @(negedge clock);
    checkOutput("midReset.busyBefore", 16'(busy), 16'h1);
    reset = 1'b0;
    #1;
    checkOutput("midReset.res",  result, 16'h0);
    checkOutput("midReset.busy", 16'(busy), 16'h0);
    enMul = 1'b0;
    doneCount = 0;
    repeat (12) begin
      @(negedge clock);
      if (done) doneCount++;
    end
    checkOutput("midReset.noDone", 16'(doneCount), 16'h0);
    reset = 1'b1;
    @(negedge clock);
    runMul(8'hFF, 8'hFF, 1'b0, "mulAfterReset");
    checkOutput("mulAfterReset.exact", result, 16'hFE01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
